// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard control.
//   FWD_RF / FWD_MEM / FWD_WB : forward-select encodings for the execute operands
//   state_t                   : memory-freeze FSM states
//   hazard_ctl_t              : bundle of stage-register stall/flush controls
package pipeline_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALU result in M
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from result in W

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctl_t;

endpackage

// File: rtl/forward_sel.sv
// Forward-select for one execute-stage operand.
//   i_rs_e                  : execute-stage source register
//   i_rd_m, i_reg_write_m   : memory-stage destination / write enable
//   i_rd_w, i_reg_write_w   : writeback-stage destination / write enable
//   o_sel                   : FWD_MEM, FWD_WB or FWD_RF (M wins over W)
module forward_sel
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_e,
  input  logic [REG_ADDR_W-1:0] i_rd_m,
  input  logic                  i_reg_write_m,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_reg_write_w,
  output logic [1:0]            o_sel
);

  logic w_match_m;
  logic w_match_w;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  assign w_match_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
  assign w_match_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

  always_comb begin
    // NOTE: default first so every path assigns o_sel and no latch is inferred.
    o_sel = FWD_RF;
    if (w_match_m) begin
      o_sel = FWD_MEM;  // younger result takes priority
    end else if (w_match_w) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage pipeline: forwarding, load-use / RAW stall,
// branch flush, data-memory freeze with watchdog, and stall/flush counters.
//   clk, rst                      : clock, synchronous active-high reset
//   rs1_d, rs2_d                  : decode-stage sources
//   rs1_e, rs2_e, rd_e            : execute-stage sources / destination
//   reg_write_e, load_e, pc_src_e : execute write enable, load flag, taken branch
//   rd_m, reg_write_m             : memory-stage destination / write enable
//   rd_w, reg_write_w             : writeback-stage destination / write enable
//   mem_busy_m                    : memory-stage access not yet complete
//   forward_a_e, forward_b_e      : execute operand forward selects
//   stall_f/d/e/m, flush_d/e/w    : stage-register controls
//   mem_timeout                   : sticky watchdog flag
//   stall_cnt, flush_cnt          : saturating event counters
module hazard_ctrl_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  reg_write_e,
  input  logic                  load_e,
  input  logic                  pc_src_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic                  mem_busy_m,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int BUSY_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs_e        (rs1_e),
    .i_rd_m        (rd_m),
    .i_reg_write_m (reg_write_m),
    .i_rd_w        (rd_w),
    .i_reg_write_w (reg_write_w),
    .o_sel         (w_fwd_a)
  );

  forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs_e        (rs2_e),
    .i_rd_m        (rd_m),
    .i_reg_write_m (reg_write_m),
    .i_rd_w        (rd_w),
    .i_reg_write_w (reg_write_w),
    .o_sel         (w_fwd_b)
  );

  assign forward_a_e = ((FWD_EN != 0) && !rst) ? w_fwd_a : FWD_RF;
  assign forward_b_e = ((FWD_EN != 0) && !rst) ? w_fwd_b : FWD_RF;

  // ---------------------------------------------------------------------------
  // Decode-stage dependency detection
  // ---------------------------------------------------------------------------
  logic w_dep_e;     // a decode source matches the execute destination
  logic w_dep_m;     // a decode source matches the memory destination
  logic w_load_use;
  logic w_raw_stall;

  assign w_dep_e = reg_write_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign w_dep_m = reg_write_m && (rd_m != '0) && ((rd_m == rs1_d) || (rd_m == rs2_d));

  assign w_load_use = load_e && w_dep_e;
  // Without forwarding every in-flight producer ahead of decode must drain;
  // W needs no stall because the register file writes before it reads.
  assign w_raw_stall = (FWD_EN == 0) && (w_dep_e || w_dep_m);

  // ---------------------------------------------------------------------------
  // Freeze FSM and stall/flush priority
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_nxt;
  hazard_ctl_t w_ctl;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctl       = '0;

    case (r_state)
      RUN:      if (mem_busy_m)  w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem_busy_m) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase

    if (rst) begin
      w_ctl = '0;
    end else if (mem_busy_m) begin
      // Freeze straight from the input so the first busy cycle already holds.
      // A taken branch in E stays pending in the frozen E register and is
      // acted on once memory releases.
      w_ctl.stall_f = 1'b1;
      w_ctl.stall_d = 1'b1;
      w_ctl.stall_e = 1'b1;
      w_ctl.stall_m = 1'b1;
      w_ctl.flush_w = 1'b1;
    end else if (pc_src_e) begin
      // The decode instruction is discarded, so its dependencies are moot.
      w_ctl.flush_d = 1'b1;
      w_ctl.flush_e = 1'b1;
    end else if (w_load_use || w_raw_stall) begin
      w_ctl.stall_f = 1'b1;
      w_ctl.stall_d = 1'b1;
      w_ctl.flush_e = 1'b1;
    end
  end

  assign stall_f = w_ctl.stall_f;
  assign stall_d = w_ctl.stall_d;
  assign stall_e = w_ctl.stall_e;
  assign stall_m = w_ctl.stall_m;
  assign flush_d = w_ctl.flush_d;
  assign flush_e = w_ctl.flush_e;
  assign flush_w = w_ctl.flush_w;

  // ---------------------------------------------------------------------------
  // Watchdog: busy_cnt tracks consecutive cycles committed to MEM_WAIT, so it
  // equals TIMEOUT right after the TIMEOUT-th busy cycle.
  // ---------------------------------------------------------------------------
  logic [BUSY_W-1:0] r_busy_cnt;
  logic [BUSY_W-1:0] w_busy_cnt_nxt;
  logic              r_mem_timeout;

  always_comb begin
    w_busy_cnt_nxt = '0;
    if (w_state_nxt == MEM_WAIT) begin
      w_busy_cnt_nxt = (r_busy_cnt == BUSY_MAX) ? r_busy_cnt : r_busy_cnt + BUSY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_busy_cnt <= w_busy_cnt_nxt;
      if ((TIMEOUT != 0) && (w_busy_cnt_nxt == BUSY_MAX)) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  assign mem_timeout = r_mem_timeout;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ctl.stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_ctl.flush_d && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit. Two instances share the inputs:
//   u_fwd  : FWD_EN=1, CNT_W=16, TIMEOUT=4
//   u_nofw : FWD_EN=0, CNT_W=2,  TIMEOUT=0 (watchdog off)
module tb_hazard_ctrl_unit;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_e, load_e, pc_src_e, reg_write_m, reg_write_w, mem_busy_m;

  logic [1:0]  a_fwd_a, a_fwd_b;
  logic        a_stall_f, a_stall_d, a_stall_e, a_stall_m;
  logic        a_flush_d, a_flush_e, a_flush_w, a_timeout;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic [1:0]  b_fwd_a, b_fwd_b;
  logic        b_stall_f, b_stall_d, b_stall_e, b_stall_m;
  logic        b_flush_d, b_flush_e, b_flush_w, b_timeout;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .FWD_EN(1), .CNT_W(16), .TIMEOUT(4)) u_fwd (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .mem_busy_m(mem_busy_m),
    .forward_a_e(a_fwd_a), .forward_b_e(a_fwd_b),
    .stall_f(a_stall_f), .stall_d(a_stall_d), .stall_e(a_stall_e), .stall_m(a_stall_m),
    .flush_d(a_flush_d), .flush_e(a_flush_e), .flush_w(a_flush_w),
    .mem_timeout(a_timeout), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .FWD_EN(0), .CNT_W(2), .TIMEOUT(0)) u_nofw (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .reg_write_e(reg_write_e), .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
    .mem_busy_m(mem_busy_m),
    .forward_a_e(b_fwd_a), .forward_b_e(b_fwd_b),
    .stall_f(b_stall_f), .stall_d(b_stall_d), .stall_e(b_stall_e), .stall_m(b_stall_m),
    .flush_d(b_flush_d), .flush_e(b_flush_e), .flush_w(b_flush_w),
    .mem_timeout(b_timeout), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 1'b0; load_e = 1'b0; pc_src_e = 1'b0;
    reg_write_m = 1'b0; reg_write_w = 1'b0; mem_busy_m = 1'b0;
  endtask

  task automatic set_load_use();
    load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
  endtask

  initial begin
    // ---- Reset: combinational outputs forced low, registers cleared ----
    clear_inputs();
    rst = 1'b1;
    set_load_use();
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
    tick();
    check("rst_fwd_a",   a_fwd_a,   2'b00);
    check("rst_stall_f", a_stall_f, 1'b0);
    check("rst_flush_e", a_flush_e, 1'b0);
    tick();
    check("rst_stall_cnt", a_stall_cnt, 0);
    check("rst_flush_cnt", a_flush_cnt, 0);
    check("rst_timeout",   a_timeout,   1'b0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // ---- Forwarding priority and x0 ----
    rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
    #1;
    check("fwd_m_prio",  a_fwd_a, 2'b10);
    check("nofw_fwd_a",  b_fwd_a, 2'b00);
    reg_write_m = 1'b0;
    #1;
    check("fwd_w",       a_fwd_a, 2'b01);
    rs1_e = 5'd0;
    #1;
    check("fwd_x0",      a_fwd_a, 2'b00);
    rs1_e = 5'd6; rd_m = 5'd6; reg_write_m = 1'b1; rs2_e = 5'd5;
    #1;
    check("fwd_a_m",     a_fwd_a, 2'b10);
    check("fwd_b_w",     a_fwd_b, 2'b01);
    clear_inputs();
    tick();

    // ---- Load-use: one stall cycle ----
    set_load_use();
    #1;
    check("lu_stall_f", a_stall_f, 1'b1);
    check("lu_stall_d", a_stall_d, 1'b1);
    check("lu_flush_e", a_flush_e, 1'b1);
    check("lu_flush_d", a_flush_d, 1'b0);
    check("lu_stall_m", a_stall_m, 1'b0);
    check("nofw_lu_stall_f", b_stall_f, 1'b1);
    tick();
    clear_inputs();
    #1;
    check("lu_released",    a_stall_f,   1'b0);
    check("lu_stall_cnt",   a_stall_cnt, 1);
    check("nofw_stall_cnt", b_stall_cnt, 1);

    // ---- Branch overrides load-use ----
    set_load_use();
    pc_src_e = 1'b1;
    #1;
    check("br_flush_d",   a_flush_d,   1'b1);
    check("br_flush_e",   a_flush_e,   1'b1);
    check("br_stall_f",   a_stall_f,   1'b0);
    check("br_flush_cnt0", a_flush_cnt, 0);
    tick();
    clear_inputs();
    #1;
    check("br_flush_cnt1", a_flush_cnt, 1);
    check("br_stall_cnt",  a_stall_cnt, 1);

    // ---- Memory freeze with deferred branch ----
    mem_busy_m = 1'b1;
    pc_src_e   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_stall_f", a_stall_f, 1'b1);
      check("frz_stall_e", a_stall_e, 1'b1);
      check("frz_stall_m", a_stall_m, 1'b1);
      check("frz_flush_w", a_flush_w, 1'b1);
      check("frz_flush_d", a_flush_d, 1'b0);
      check("frz_flush_e", a_flush_e, 1'b0);
      tick();
    end
    mem_busy_m = 1'b0;
    #1;
    check("rel_flush_d", a_flush_d, 1'b1);
    check("rel_flush_e", a_flush_e, 1'b1);
    check("rel_stall_f", a_stall_f, 1'b0);
    check("rel_stall_m", a_stall_m, 1'b0);
    check("rel_flush_w", a_flush_w, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("rel_flush_cnt",  a_flush_cnt, 2);
    check("rel_stall_cnt",  a_stall_cnt, 4);
    check("rel_no_timeout", a_timeout,   1'b0);
    check("nofw_sat_cnt",   b_stall_cnt, 3);

    // ---- Watchdog: TIMEOUT=4, six busy cycles ----
    mem_busy_m = 1'b1;
    tick(); tick(); tick();
    check("wd_after3", a_timeout, 1'b0);
    tick();
    check("wd_after4", a_timeout, 1'b1);
    tick(); tick();
    mem_busy_m = 1'b0;
    tick();
    check("wd_sticky",      a_timeout,   1'b1);
    check("wd_stall_cnt",   a_stall_cnt, 10);
    check("wd_disabled",    b_timeout,   1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("wd_rst_clear",   a_timeout,   1'b0);
    check("rst2_stall_cnt", a_stall_cnt, 0);
    check("rst2_flush_cnt", a_flush_cnt, 0);
    check("rst2_nofw_cnt",  b_stall_cnt, 0);

    // ---- No-forwarding RAW stall and 2-bit counter saturation ----
    rd_m = 5'd3; reg_write_m = 1'b1; rs1_d = 5'd3; rs1_e = 5'd3;
    #1;
    check("raw_stall_f", b_stall_f, 1'b1);
    check("raw_stall_d", b_stall_d, 1'b1);
    check("raw_flush_e", b_flush_e, 1'b1);
    check("raw_fwd_a",   b_fwd_a,   2'b00);
    check("fw_fwd_a",    a_fwd_a,   2'b10);
    check("fw_no_stall", a_stall_f, 1'b0);
    tick(); tick();
    check("raw_cnt2", b_stall_cnt, 2);
    tick(); tick(); tick();
    check("raw_cnt_sat", b_stall_cnt, 3);
    check("fw_cnt_zero", a_stall_cnt, 0);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
